// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared definitions for the iterative DES round controller and its key
// schedule helpers.
//   state_t    : controller state encoding
//   DES_ROUNDS : default number of Feistel rounds
//   ENC_SHIFT  : per-round C/D left-rotate amount for encryption
// -----------------------------------------------------------------------------
package des_pkg;

  localparam int DES_ROUNDS = 16;

  typedef enum logic [2:0] {
    IDLE,
    IP_REQ,
    IP_WAIT,
    ROUND,
    FP_REQ,
    FP_WAIT,
    DONE
  } state_t;

  // Element 0 is round 0. The sixteen entries sum to 28, so C/D return to
  // their starting alignment after a full encryption.
  localparam logic [1:0] ENC_SHIFT [DES_ROUNDS] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

endpackage : des_pkg

// File: rtl/des_shift_lut.sv
// -----------------------------------------------------------------------------
// des_shift_lut
// Combinational key-schedule lookup: round index and mode to the C/D rotate
// amount and direction.
//   round_idx in  4  current round 0..15
//   mode      in  1  0 = encrypt, 1 = decrypt
//   key_shift out 2  rotate amount (0, 1 or 2)
//   key_dir   out 1  0 = rotate left, 1 = rotate right
// Build option: DES_DECRYPT_EN enables the decrypt schedule; without it the
// mode input is ignored and only the encrypt table exists.
// -----------------------------------------------------------------------------
module des_shift_lut
  import des_pkg::*;
(
  input  logic [3:0] round_idx,
  input  logic       mode,
  output logic [1:0] key_shift,
  output logic       key_dir
);

`ifdef DES_DECRYPT_EN
  // Decrypt rotates right by the same amounts, except that round 0 does not
  // rotate at all: the PC1 key is already aligned with encrypt round 15.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path through
    // the block can leave it unassigned and infer a latch.
    key_shift = ENC_SHIFT[round_idx];
    if (mode && (round_idx == 4'd0)) begin
      key_shift = 2'd0;
    end
  end

  assign key_dir = mode;
`else
  assign key_shift = ENC_SHIFT[round_idx];
  assign key_dir   = 1'b0;

  logic unused_mode;
  assign unused_mode = mode;
`endif

endmodule : des_shift_lut

// File: rtl/des_round_ctrl.sv
// -----------------------------------------------------------------------------
// des_round_ctrl
// Top-level sequencer for the iterative DES datapath. One accepted request
// walks through: initial permutation, NUM_ROUNDS Feistel rounds, final
// permutation, then a one-cycle done pulse.
//   clk, rst_n  clock, asynchronous active-low reset
//   start_i     block request (sampled in IDLE only)
//   mode_i      0 = encrypt, 1 = decrypt (latched on accept)
//   ready_o     high in IDLE
//   busy_o      high outside IDLE
//   iIp / fIp   initial-permutation start pulse / finished flag
//   key_load    one-cycle pulse: load PC1 key into C/D
//   round_en    one-cycle pulse on the first cycle of each round
//   round_idx   current round, held for the whole round
//   key_shift   C/D rotate amount (valid with round_en, else 0)
//   key_dir     0 = rotate left, 1 = rotate right
//   iFp / fFp   final-permutation start pulse / finished flag
//   done_o      one-cycle pulse when the block completes
// Parameters: NUM_ROUNDS (1..16), ROUND_CYCLES (>=1).
// Build option: DES_DECRYPT_EN enables the latched mode and decrypt schedule.
// -----------------------------------------------------------------------------
module des_round_ctrl
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS   = DES_ROUNDS,
  parameter int ROUND_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       mode_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic       iIp,
  input  logic       fIp,
  output logic       key_load,
  output logic       round_en,
  output logic [3:0] round_idx,
  output logic [1:0] key_shift,
  output logic       key_dir,
  output logic       iFp,
  input  logic       fFp,
  output logic       done_o
);

  localparam int              CW         = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
  localparam logic [3:0]      LAST_ROUND = 4'(NUM_ROUNDS - 1);
  localparam logic [CW-1:0]   LAST_CYC   = CW'(ROUND_CYCLES - 1);

  state_t        state_q, state_d;
  logic [3:0]    round_q, round_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic          mode_q;
  logic [1:0]    lut_shift;
  logic          lut_dir;

  // ---------------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= '0;
      cyc_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      state_q <= state_d;
      round_q <= round_d;
      cyc_q   <= cyc_d;
    end
  end

`ifdef DES_DECRYPT_EN
  // Mode is captured only on the accept edge, so mode_i changes while busy
  // cannot disturb a block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
    end else if ((state_q == IDLE) && start_i) begin
      mode_q <= mode_i;
    end
  end
`else
  assign mode_q = 1'b0;

  logic unused_mode;
  assign unused_mode = mode_i;
`endif

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    cyc_d    = cyc_q;
    ready_o  = 1'b0;
    busy_o   = 1'b1;
    iIp      = 1'b0;
    key_load = 1'b0;
    round_en = 1'b0;
    iFp      = 1'b0;
    done_o   = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        busy_o  = 1'b0;
        if (start_i) begin
          state_d = IP_REQ;
        end
      end

      IP_REQ: begin
        // The key is loaded while the IP stage runs so C/D are ready for
        // round 0.
        iIp      = 1'b1;
        key_load = 1'b1;
        state_d  = IP_WAIT;
      end

      IP_WAIT: begin
        if (fIp) begin
          state_d = ROUND;
          round_d = '0;
          cyc_d   = '0;
        end
      end

      ROUND: begin
        round_en = (cyc_q == '0);
        if (cyc_q == LAST_CYC) begin
          cyc_d = '0;
          if (round_q == LAST_ROUND) begin
            state_d = FP_REQ;
            round_d = '0;
          end else begin
            round_d = round_q + 4'd1;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      FP_REQ: begin
        iFp     = 1'b1;
        state_d = FP_WAIT;
      end

      FP_WAIT: begin
        if (fFp) begin
          state_d = DONE;
        end
      end

      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Key schedule controls
  // ---------------------------------------------------------------------------
  des_shift_lut u_shift_lut (
    .round_idx (round_q),
    .mode      (mode_q),
    .key_shift (lut_shift),
    .key_dir   (lut_dir)
  );

  assign round_idx = round_q;
  // Gated so the shift amount reads 0 outside round_en, including in reset.
  assign key_shift = round_en ? lut_shift : 2'd0;
  assign key_dir   = lut_dir;

endmodule : des_round_ctrl

// File: tb/tb_des_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_des_round_ctrl
// Self-checking bench for des_round_ctrl. Two instances: dut (ROUND_CYCLES=1)
// and dut3 (ROUND_CYCLES=3). Expected pulse events (cycle relative to the
// start-accept edge, plus round index/shift/dir) are queued when a block is
// launched and popped by a negedge monitor whenever the DUT emits a pulse.
// Cycle c is the clock period that follows edge (accept + c - 1).
// -----------------------------------------------------------------------------
module tb_des_round_ctrl;

  typedef struct packed {
    int         cyc;
    logic       ip;
    logic       kl;
    logic       ren;
    logic [3:0] idx;
    logic [1:0] sh;
    logic       dir;
    logic       fp;
    logic       dn;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic start0 = 1'b0, start1 = 1'b0, mode0 = 1'b0, mode1 = 1'b0;
  logic start_stray = 1'b0, ffp_stray = 1'b0;
  logic fip0 = 1'b0, fip1 = 1'b0, ffp0 = 1'b0, ffp1 = 1'b0;

  logic       ready0, busy0, iip0, kl0, ren0, dir0, ifp0, done0;
  logic       ready1, busy1, iip1, kl1, ren1, dir1, ifp1, done1;
  logic [3:0] idx0, idx1;
  logic [1:0] sh0, sh1;

  int ip_delay [2] = '{1, 1};
  int fp_delay [2] = '{1, 1};
  int edge_cnt = 0;
  int acc [2]  = '{0, 0};
  int vectors     = 0;
  int miscompares = 0;

  ev_t exp_q [2][$];

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  des_round_ctrl #(.NUM_ROUNDS(16), .ROUND_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start0 | start_stray), .mode_i(mode0),
    .ready_o(ready0), .busy_o(busy0), .iIp(iip0), .fIp(fip0), .key_load(kl0),
    .round_en(ren0), .round_idx(idx0), .key_shift(sh0), .key_dir(dir0),
    .iFp(ifp0), .fFp(ffp0 | ffp_stray), .done_o(done0)
  );

  des_round_ctrl #(.NUM_ROUNDS(16), .ROUND_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .mode_i(mode1),
    .ready_o(ready1), .busy_o(busy1), .iIp(iip1), .fIp(fip1), .key_load(kl1),
    .round_en(ren1), .round_idx(idx1), .key_shift(sh1), .key_dir(dir1),
    .iFp(ifp1), .fFp(ffp1), .done_o(done1)
  );

  // Stage responders: finished flag rises ip/fp_delay cycles after the start
  // pulse and lasts one cycle.
  always begin
    @(negedge clk);
    if (rst_n && iip0) begin
      repeat (ip_delay[0]) @(posedge clk);
      #1 fip0 = 1'b1;
      @(posedge clk);
      #1 fip0 = 1'b0;
    end
  end

  always begin
    @(negedge clk);
    if (rst_n && ifp0) begin
      repeat (fp_delay[0]) @(posedge clk);
      #1 ffp0 = 1'b1;
      @(posedge clk);
      #1 ffp0 = 1'b0;
    end
  end

  always begin
    @(negedge clk);
    if (rst_n && iip1) begin
      repeat (ip_delay[1]) @(posedge clk);
      #1 fip1 = 1'b1;
      @(posedge clk);
      #1 fip1 = 1'b0;
    end
  end

  always begin
    @(negedge clk);
    if (rst_n && ifp1) begin
      repeat (fp_delay[1]) @(posedge clk);
      #1 ffp1 = 1'b1;
      @(posedge clk);
      #1 ffp1 = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic exp_dec(input logic md);
`ifdef DES_DECRYPT_EN
    return md;
`else
    return md & 1'b0;
`endif
  endfunction

  function automatic logic [1:0] exp_shift(input int r, input logic md);
    if (exp_dec(md) && (r == 0)) return 2'd0;
    if ((r == 0) || (r == 1) || (r == 8) || (r == 15)) return 2'd1;
    return 2'd2;
  endfunction

  function automatic ev_t mk_ev(input int cyc, input logic ip, kl, ren,
                                input logic [3:0] idx, input logic [1:0] sh,
                                input logic dir, fp, dn);
    ev_t e;
    e.cyc = cyc; e.ip = ip; e.kl = kl; e.ren = ren; e.idx = idx;
    e.sh = sh; e.dir = dir; e.fp = fp; e.dn = dn;
    return e;
  endfunction

  // Queue the pulse events of one block; rounds after last_round (and the
  // FP/done pulses) are omitted when the block is to be aborted.
  task automatic push_block(input int k, input int nr, input int rc, input logic md,
                            input int ipd, input int fpd, input int last_round);
    int base;
    int fpreq;
    base = 2 + ipd;
    exp_q[k].push_back(mk_ev(1, 1'b1, 1'b1, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0));
    for (int r = 0; r <= last_round; r++) begin
      exp_q[k].push_back(mk_ev(base + r * rc, 1'b0, 1'b0, 1'b1, 4'(r),
                               exp_shift(r, md), exp_dec(md), 1'b0, 1'b0));
    end
    if (last_round == nr - 1) begin
      fpreq = base + nr * rc;
      exp_q[k].push_back(mk_ev(fpreq, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1, 1'b0));
      exp_q[k].push_back(mk_ev(fpreq + fpd + 1, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1));
    end
  endtask

  // Scoreboard monitor: records the accept edge and compares each pulse cycle.
  task automatic monitor(input int k, input logic st, rdy, ip, kl, ren,
                         input logic [3:0] idx, input logic [1:0] sh,
                         input logic dir, fp, dn);
    ev_t obs;
    ev_t ex;
    if (!rst_n) return;
    if (rdy && st) acc[k] = edge_cnt + 1;
    if (ip | kl | ren | fp | dn) begin
      obs = mk_ev(edge_cnt - acc[k] + 1, ip, kl, ren, ren ? idx : 4'd0,
                  ren ? sh : 2'd0, ren ? dir : 1'b0, fp, dn);
      vectors++;
      if (exp_q[k].size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse dut%0d: got cyc=%0d ip=%b kl=%b ren=%b idx=%0d fp=%b done=%b, required no pulse",
                 k, obs.cyc, ip, kl, ren, idx, fp, dn);
      end else begin
        ex = exp_q[k].pop_front();
        if (obs !== ex) begin
          miscompares++;
          $display("FAIL event dut%0d: got cyc=%0d ip=%b kl=%b ren=%b idx=%0d sh=%0d dir=%b fp=%b done=%b, required cyc=%0d ip=%b kl=%b ren=%b idx=%0d sh=%0d dir=%b fp=%b done=%b",
                   k, obs.cyc, obs.ip, obs.kl, obs.ren, obs.idx, obs.sh, obs.dir, obs.fp, obs.dn,
                   ex.cyc, ex.ip, ex.kl, ex.ren, ex.idx, ex.sh, ex.dir, ex.fp, ex.dn);
        end
      end
    end
  endtask

  always @(negedge clk) monitor(0, start0 | start_stray, ready0, iip0, kl0, ren0, idx0, sh0, dir0, ifp0, done0);
  always @(negedge clk) monitor(1, start1, ready1, iip1, kl1, ren1, idx1, sh1, dir1, ifp1, done1);

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic start_block(input int k, input logic md);
    @(posedge clk);
    #1;
    if (k == 0) begin start0 = 1'b1; mode0 = md; end
    else        begin start1 = 1'b1; mode1 = md; end
    @(posedge clk);
    #1;
    if (k == 0) start0 = 1'b0; else start1 = 1'b0;
  endtask

  task automatic wait_drain(input int k, input int budget, input string name);
    int n;
    n = 0;
    while ((exp_q[k].size() != 0) && (n < budget)) begin
      @(posedge clk);
      n++;
    end
    vectors++;
    if (exp_q[k].size() != 0) begin
      miscompares++;
      $display("FAIL %s_timeout dut%0d: got %0d events outstanding after %0d cycles, required 0",
               name, k, exp_q[k].size(), budget);
      exp_q[k].delete();
    end
  endtask

  task automatic check_idle(input int k, input string name);
    logic [1:0] rb;
    repeat (3) @(negedge clk);
    rb = (k == 0) ? {ready0, busy0} : {ready1, busy1};
    vectors++;
    if (rb !== 2'b10) begin
      miscompares++;
      $display("FAIL %s_idle dut%0d: got ready/busy=%b, required 10", name, k, rb);
    end
  endtask

  task automatic run_block(input int k, input logic md, input int ipd, input int fpd,
                           input int rc, input string name);
    ip_delay[k] = ipd;
    fp_delay[k] = fpd;
    push_block(k, 16, rc, md, ipd, fpd, 15);
    start_block(k, md);
    wait_drain(k, 200, name);
    check_idle(k, name);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({ready0, busy0, iip0, kl0, ren0, idx0, sh0, dir0, ifp0, done0} !== {2'b10, 12'd0}) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b, required %b",
               {ready0, busy0, iip0, kl0, ren0, idx0, sh0, dir0, ifp0, done0}, {2'b10, 12'd0});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      vectors++;
      if ({ready0, busy0, ready1, busy1} !== 4'b1010) begin
        miscompares++;
        $display("FAIL idle_hold cycle %0d: got ready/busy dut=%b%b dut3=%b%b, required 10 10",
                 i, ready0, busy0, ready1, busy1);
      end
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ready0, busy0, iip0, kl0, ren0, idx0, sh0, dir0, ifp0, done0} !== {2'b10, 12'd0}) begin
      miscompares++;
      $display("FAIL reset_mid_idle: got %b, required %b",
               {ready0, busy0, iip0, kl0, ren0, idx0, sh0, dir0, ifp0, done0}, {2'b10, 12'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_encrypt();
    run_block(0, 1'b0, 1, 1, 1, "encrypt");
  endtask

  task automatic test_decrypt();
    run_block(0, 1'b1, 1, 1, 1, "decrypt");
  endtask

  // fIp late by 7 cycles; a stray start and a stray fFp land inside ROUND.
  task automatic test_stray_flags();
    fork
      run_block(0, 1'b0, 8, 1, 1, "stray");
      begin
        repeat (13) @(posedge clk);
        #1 start_stray = 1'b1;
        @(posedge clk);
        #1 start_stray = 1'b0;
        repeat (2) @(posedge clk);
        #1 ffp_stray = 1'b1;
        @(posedge clk);
        #1 ffp_stray = 1'b0;
      end
    join
  endtask

  task automatic test_round_cycles();
    fork
      run_block(1, 1'b0, 1, 1, 3, "round_cycles");
      begin
        repeat (2) @(posedge clk);
        for (int c = 1; c <= 52; c++) begin
          @(negedge clk);
          if ((c >= 3) && (c <= 50)) begin
            vectors++;
            if ({ren1, idx1} !== {((c - 3) % 3 == 0), 4'((c - 3) / 3)}) begin
              miscompares++;
              $display("FAIL round_hold cycle %0d: got ren=%b idx=%0d, required ren=%b idx=%0d",
                       c, ren1, idx1, ((c - 3) % 3 == 0), (c - 3) / 3);
            end
          end
        end
      end
    join
  endtask

  task automatic test_reset_mid_block();
    int n;
    ip_delay[0] = 1;
    fp_delay[0] = 1;
    push_block(0, 16, 1, 1'b0, 1, 1, 5);
    start_block(0, 1'b0);
    n = 0;
    @(negedge clk);
    while (!(ren0 && (idx0 == 4'd5)) && (n < 60)) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!(ren0 && (idx0 == 4'd5))) begin
      miscompares++;
      $display("FAIL reach_round5: got idx=%0d ren=%b after %0d cycles, required idx=5 ren=1", idx0, ren0, n);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({ready0, busy0, ren0, idx0, done0} !== 8'b1000_0000) begin
      miscompares++;
      $display("FAIL reset_abort: got ready=%b busy=%b ren=%b idx=%0d done=%b, required 1 0 0 0 0",
               ready0, busy0, ren0, idx0, done0);
    end
    wait_drain(0, 1, "abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    run_block(0, 1'b0, 1, 1, 1, "after_abort");
  endtask

  // Start held high: second block accepted the cycle after DONE. mode_i
  // flips during block 1 and must only take effect for block 2.
  task automatic test_back_to_back();
    int n;
    ip_delay[0] = 1;
    fp_delay[0] = 1;
    push_block(0, 16, 1, 1'b0, 1, 1, 15);
    push_block(0, 16, 1, 1'b1, 1, 1, 15);
    @(posedge clk);
    #1 mode0 = 1'b0;
    start0 = 1'b1;
    n = 0;
    @(negedge clk);
    while (!done0 && (n < 60)) begin
      if (n == 3) mode0 = 1'b1;
      @(negedge clk);
      n++;
    end
    vectors++;
    if (done0 !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first_done: got done=%b after %0d cycles, required 1", done0, n);
    end
    repeat (2) @(posedge clk);
    #1 start0 = 1'b0;
    mode0 = 1'b0;
    wait_drain(0, 80, "b2b");
    check_idle(0, "b2b");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, required finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_stray_flags();
    test_round_cycles();
    test_reset_mid_block();
    test_back_to_back();
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_des_round_ctrl
